regfile: RTL and testbench
==========================

REGFILE -- requirements
Module: regfile

Interface
REQ-001 SHALL define parameter REG_NUM, default 32: number of architectural registers.
REQ-002 SHALL define parameter DATA_W, default 32: register data width.
REQ-003 SHALL define parameter CNT_W, default 2: width of each per-register pending-write counter.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous and active-low.
REQ-006 SHALL have port we  input  1  writeback write enable.
REQ-007 SHALL have port waddr  input  5  writeback target register.
REQ-008 SHALL have port wdata  input  DATA_W  writeback data.
REQ-009 SHALL have port re1  input  1  read-port-1 enable, driven by the decode stage.
REQ-010 SHALL have port raddr1  input  5  read-port-1 address.
REQ-011 SHALL have port rdata1  output  DATA_W  read-port-1 data, combinational.
REQ-012 SHALL have port re2  input  1  read-port-2 enable.
REQ-013 SHALL have port raddr2  input  5  read-port-2 address.
REQ-014 SHALL have port rdata2  output  DATA_W  read-port-2 data, combinational.
REQ-015 SHALL have port issue_we  input  1  decode stage is issuing an instruction that will write a register.
REQ-016 SHALL have port issue_addr  input  5  destination register of the issuing instruction.
REQ-017 SHALL have port stallreq  output  1  decode stage must hold; the current issue is not accepted.

Function
REQ-018 SHALL hold REG_NUM x DATA_W storage; register 0 always reads 0, and writes to it are discarded.
REQ-019 SHALL write wdata into waddr on a rising clk edge when we=1 and waddr!=0.
REQ-020 SHALL drive rdataN=0 when reN=0 or raddrN=0.
REQ-021 SHALL drive rdataN=wdata (same-cycle bypass) when reN=1, we=1 and waddr=raddrN!=0.
REQ-022 SHALL otherwise drive rdataN from storage[raddrN].
REQ-023 SHALL keep one CNT_W-bit pending counter per register; cnt[0] stays 0.
REQ-024 SHALL define issue_fire = issue_we & ~stallreq & (issue_addr!=0).
REQ-025 SHALL define wb_fire = we & (waddr!=0).
REQ-026 SHALL update cnt[r] each edge: +1 if issue_fire targets r only, -1 if wb_fire targets r only, unchanged if both or neither.
REQ-027 SHALL not decrement a counter at 0 (a writeback to a non-pending register still writes data).
REQ-028 SHALL define hazardN = reN & (raddrN!=0) & (cnt[raddrN]!=0) & ~(cnt[raddrN]=1 & wb_fire & waddr=raddrN).
REQ-029 SHALL define full = issue_we & (issue_addr!=0) & (cnt[issue_addr] = 2^CNT_W-1).
REQ-030 SHALL assert stallreq = hazard1 | hazard2 | full, combinationally within the same cycle.
REQ-031 SHALL keep stallreq free of any dependence on the issuing instruction's own destination counter update (no self-hazard).

Reset
REQ-032 SHALL clear all storage and all counters immediately while rst=0, independent of clk.
REQ-033 SHALL drive rdata1=0, rdata2=0 and stallreq=0 while rst=0.
REQ-034 SHALL ignore we and issue_we while rst=0; the first update occurs on the first rising edge with rst=1.
REQ-035 SHALL discard all in-flight pending state when reset is asserted mid-operation; no stale stall may survive reset.

Verification
REQ-036 SHALL cover: we=1 waddr=5 wdata=0xDEADBEEF, then re1=1 raddr1=5 on the next cycle -> rdata1=0xDEADBEEF; with raddr1=0 -> 0.
REQ-037 SHALL cover: we=1 waddr=7 wdata=0x1234 in the same cycle as re2=1 raddr2=7 -> rdata2=0x1234 via bypass; stallreq=0.
REQ-038 SHALL cover: issue_we=1 issue_addr=3 (cnt 0->1), next cycle re1=1 raddr1=3 -> stallreq=1; the cycle with we=1 waddr=3 -> stallreq=0 and rdata1=wdata.
REQ-039 SHALL cover: three fired issues to r9 (cnt=3), then a fourth issue_we to r9 -> stallreq=1 and cnt stays 3; simultaneous issue and writeback to r9 -> cnt unchanged.
REQ-040 SHALL cover: issue_we=1 issue_addr=0 and we=1 waddr=0 wdata=0xFFFF -> cnt[0]=0, storage[0] reads 0, stallreq=0.
REQ-041 SHALL cover: cnt[4]=2 and r4=0xAA, then pull rst low between clock edges -> rdata=0 and stallreq=0 at once; after release, raddr1=4 -> rdata1=0 with no stall.

Source files
------------

// File: rtl/regfile.sv
// Register file with per-register pending-write scoreboard and writeback bypass.
// Reads are combinational (0 cycles). stallreq holds decode when an operand is pending or its counter would saturate.
module regfile #(
    parameter int REG_NUM = 32,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [4:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [4:0]        raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [4:0]        raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              issue_we,
    input  logic [4:0]        issue_addr,
    output logic              stallreq
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] regs_q [REG_NUM];
    logic [DATA_W-1:0] regs_d [REG_NUM];
    logic [CNT_W-1:0]  cnt_q  [REG_NUM];
    logic [CNT_W-1:0]  cnt_d  [REG_NUM];

    logic              wb_fire;
    logic              issue_fire;
    logic              hazard1;
    logic              hazard2;
    logic              full;
    logic              stall_raw;
    logic              rd1_ok;
    logic              rd2_ok;
    logic              iss_ok;
    logic [CNT_W-1:0]  rd1_cnt;
    logic [CNT_W-1:0]  rd2_cnt;
    logic [CNT_W-1:0]  iss_cnt;

    // Register 0 and any address beyond REG_NUM behave as a hard-wired zero.
    function automatic logic addr_ok(input logic [4:0] a);
        return (a != 5'd0) && (32'(a) < REG_NUM);
    endfunction

    always_comb begin
        wb_fire = we && addr_ok(waddr);
        rd1_ok  = addr_ok(raddr1);
        rd2_ok  = addr_ok(raddr2);
        iss_ok  = addr_ok(issue_addr);
        rd1_cnt = '0;
        rd2_cnt = '0;
        iss_cnt = '0;
        if (rd1_ok) rd1_cnt = cnt_q[raddr1];
        if (rd2_ok) rd2_cnt = cnt_q[raddr2];
        if (iss_ok) iss_cnt = cnt_q[issue_addr];
    end

    // A read of a register whose last outstanding write lands this cycle is
    // satisfied by the bypass, so it does not stall.
    always_comb begin
        hazard1 = re1 && rd1_ok && (rd1_cnt != '0)
                  && !((rd1_cnt == CNT_ONE) && wb_fire && (waddr == raddr1));
        hazard2 = re2 && rd2_ok && (rd2_cnt != '0)
                  && !((rd2_cnt == CNT_ONE) && wb_fire && (waddr == raddr2));
        full    = issue_we && iss_ok && (iss_cnt == CNT_MAX);
        // Built only from current counters: the issuing instruction never
        // stalls on its own destination update.
        stall_raw  = hazard1 || hazard2 || full;
        issue_fire = issue_we && iss_ok && !stall_raw;
        stallreq   = rst && stall_raw;
    end

    always_comb begin
        rdata1 = '0;
        if (rst && re1 && rd1_ok) begin
            if (wb_fire && (waddr == raddr1)) rdata1 = wdata;
            else                              rdata1 = regs_q[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (rst && re2 && rd2_ok) begin
            if (wb_fire && (waddr == raddr2)) rdata2 = wdata;
            else                              rdata2 = regs_q[raddr2];
        end
    end

    always_comb begin
        logic inc;
        logic dec;
        regs_d[0] = '0;
        cnt_d[0]  = '0;
        for (int r = 1; r < REG_NUM; r++) begin
            regs_d[r] = regs_q[r];
            cnt_d[r]  = cnt_q[r];
            inc = issue_fire && (issue_addr == 5'(r));
            dec = wb_fire && (waddr == 5'(r));
            if (dec) regs_d[r] = wdata;
            // Saturation is prevented upstream by the full stall; a stray
            // writeback to an idle register leaves the counter at zero.
            if (inc && !dec)
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            else if (dec && !inc && (cnt_q[r] != '0))
                cnt_d[r] = cnt_q[r] - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < REG_NUM; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
        end else begin
            for (int r = 0; r < REG_NUM; r++) begin
                regs_q[r] <= regs_d[r];
                cnt_q[r]  <= cnt_d[r];
            end
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus randomized traffic vs a reference model.
module tb_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        re1 = 1'b0;
    logic [4:0]  raddr1 = '0;
    logic [31:0] rdata1;
    logic        re2 = 1'b0;
    logic [4:0]  raddr2 = '0;
    logic [31:0] rdata2;
    logic        issue_we = 1'b0;
    logic [4:0]  issue_addr = '0;
    logic        stallreq;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_mem [32];
    int          m_cnt [32];

    regfile #(.REG_NUM(32), .DATA_W(32), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .issue_we(issue_we), .issue_addr(issue_addr), .stallreq(stallreq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_read(input logic re, input logic [4:0] ra);
        if (!rst || !re || ra == 5'd0) return 32'h0;
        if (we && waddr == ra) return wdata;
        return m_mem[ra];
    endfunction

    function automatic logic m_stall();
        logic h1, h2, fl;
        if (!rst) return 1'b0;
        h1 = re1 && raddr1 != 0 && m_cnt[raddr1] > 0
             && !(m_cnt[raddr1] == 1 && we && waddr == raddr1);
        h2 = re2 && raddr2 != 0 && m_cnt[raddr2] > 0
             && !(m_cnt[raddr2] == 1 && we && waddr == raddr2);
        fl = issue_we && issue_addr != 0 && m_cnt[issue_addr] == (1 << 2) - 1;
        return h1 || h2 || fl;
    endfunction

    function automatic void m_clock();
        logic fi, wf;
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i] = 32'h0;
                m_cnt[i] = 0;
            end
            return;
        end
        fi = issue_we && issue_addr != 0 && !m_stall();
        wf = we && waddr != 0;
        if (wf) m_mem[waddr] = wdata;
        if (fi && !(wf && waddr == issue_addr)) m_cnt[issue_addr] += 1;
        if (wf && !(fi && issue_addr == waddr) && m_cnt[waddr] > 0) m_cnt[waddr] -= 1;
    endfunction

    task automatic tick();
        m_clock();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        we = 0; waddr = 0; wdata = 0;
        re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
        issue_we = 0; issue_addr = 0;
    endtask

    task automatic test_reset();
        m_clock();
        #3;
        re1 = 1; raddr1 = 1; we = 1; waddr = 1; wdata = 32'h5;
        issue_we = 1; issue_addr = 1;
        #1;
        checks++;
        if (rdata1 !== 32'h0) begin errors++; $display("FAIL reset_rdata1 got %h exp %h", rdata1, 32'h0); end
        checks++;
        if (stallreq !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stallreq); end
        tick();
        idle();
        rst = 1;
        re1 = 1; raddr1 = 1;
        #1;
        checks++;
        if (rdata1 !== 32'h0) begin errors++; $display("FAIL reset_ignored_we got %h exp %h", rdata1, 32'h0); end
        tick();
    endtask

    task automatic test_write_read();
        idle();
        we = 1; waddr = 5; wdata = 32'hDEADBEEF;
        #1;
        tick();
        idle();
        re1 = 1; raddr1 = 5;
        #1;
        checks++;
        if (rdata1 !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd got %h exp %h", rdata1, 32'hDEADBEEF); end
        raddr1 = 0;
        #1;
        checks++;
        if (rdata1 !== 32'h0) begin errors++; $display("FAIL rd_r0 got %h exp %h", rdata1, 32'h0); end
        tick();
    endtask

    task automatic test_bypass();
        idle();
        we = 1; waddr = 7; wdata = 32'h1234; re2 = 1; raddr2 = 7;
        #1;
        checks++;
        if (rdata2 !== 32'h1234) begin errors++; $display("FAIL bypass got %h exp %h", rdata2, 32'h1234); end
        checks++;
        if (stallreq !== 1'b0) begin errors++; $display("FAIL bypass_stall got %b exp 0", stallreq); end
        tick();
    endtask

    task automatic test_hazard();
        idle();
        issue_we = 1; issue_addr = 3;
        #1;
        checks++;
        if (stallreq !== 1'b0) begin errors++; $display("FAIL haz_issue got %b exp 0", stallreq); end
        tick();
        idle();
        re1 = 1; raddr1 = 3;
        #1;
        checks++;
        if (stallreq !== 1'b1) begin errors++; $display("FAIL haz_pending got %b exp 1", stallreq); end
        tick();
        re1 = 1; raddr1 = 3; we = 1; waddr = 3; wdata = 32'h55;
        #1;
        checks++;
        if (stallreq !== 1'b0) begin errors++; $display("FAIL haz_wb_stall got %b exp 0", stallreq); end
        checks++;
        if (rdata1 !== 32'h55) begin errors++; $display("FAIL haz_wb_data got %h exp %h", rdata1, 32'h55); end
        tick();
        idle();
    endtask

    task automatic test_full();
        idle();
        for (int i = 0; i < 3; i++) begin
            issue_we = 1; issue_addr = 9;
            #1;
            checks++;
            if (stallreq !== 1'b0) begin errors++; $display("FAIL full_fill%0d got %b exp 0", i, stallreq); end
            tick();
        end
        #1;
        checks++;
        if (stallreq !== 1'b1) begin errors++; $display("FAIL full_stall got %b exp 1", stallreq); end
        tick();
        idle();
        re1 = 1; raddr1 = 9; we = 1; waddr = 9; wdata = 32'h99;
        #1;
        checks++;
        if (stallreq !== 1'b1) begin errors++; $display("FAIL full_cnt3 got %b exp 1", stallreq); end
        checks++;
        if (rdata1 !== 32'h99) begin errors++; $display("FAIL full_byp got %h exp %h", rdata1, 32'h99); end
        tick();
        idle();
        issue_we = 1; issue_addr = 9; we = 1; waddr = 9; wdata = 32'h9A;
        #1;
        checks++;
        if (stallreq !== 1'b0) begin errors++; $display("FAIL full_both got %b exp 0", stallreq); end
        tick();
        idle();
        re1 = 1; raddr1 = 9; we = 1; waddr = 9; wdata = 32'h9B;
        #1;
        checks++;
        if (stallreq !== 1'b1) begin errors++; $display("FAIL full_cnt2 got %b exp 1", stallreq); end
        tick();
        wdata = 32'hA5;
        #1;
        checks++;
        if (stallreq !== 1'b0) begin errors++; $display("FAIL full_cnt1 got %b exp 0", stallreq); end
        tick();
        idle();
        re1 = 1; raddr1 = 9;
        #1;
        checks++;
        if (stallreq !== 1'b0) begin errors++; $display("FAIL full_drain got %b exp 0", stallreq); end
        checks++;
        if (rdata1 !== 32'hA5) begin errors++; $display("FAIL full_data got %h exp %h", rdata1, 32'hA5); end
        tick();
    endtask

    task automatic test_zero();
        idle();
        issue_we = 1; issue_addr = 0; we = 1; waddr = 0; wdata = 32'hFFFF;
        re1 = 1; raddr1 = 0;
        #1;
        checks++;
        if (rdata1 !== 32'h0) begin errors++; $display("FAIL zero_byp got %h exp 0", rdata1); end
        checks++;
        if (stallreq !== 1'b0) begin errors++; $display("FAIL zero_stall got %b exp 0", stallreq); end
        tick();
        idle();
        re2 = 1; raddr2 = 0; issue_we = 1; issue_addr = 0;
        #1;
        checks++;
        if (rdata2 !== 32'h0 || stallreq !== 1'b0) begin
            errors++; $display("FAIL zero_after got %h/%b exp 0/0", rdata2, stallreq);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        idle();
        we = 1; waddr = 4; wdata = 32'hAA;
        #1;
        tick();
        idle();
        issue_we = 1; issue_addr = 4;
        #1;
        tick();
        #1;
        tick();
        idle();
        re1 = 1; raddr1 = 4;
        #1;
        checks++;
        if (stallreq !== 1'b1 || rdata1 !== 32'hAA) begin
            errors++; $display("FAIL mid_pre got %h/%b exp %h/1", rdata1, stallreq, 32'hAA);
        end
        #1;
        rst = 0;
        #1;
        checks++;
        if (rdata1 !== 32'h0 || stallreq !== 1'b0) begin
            errors++; $display("FAIL mid_async got %h/%b exp 0/0", rdata1, stallreq);
        end
        we = 1; waddr = 4; wdata = 32'h77; issue_we = 1; issue_addr = 4;
        tick();
        rst = 1;
        idle();
        re1 = 1; raddr1 = 4;
        #1;
        checks++;
        if (rdata1 !== 32'h0 || stallreq !== 1'b0) begin
            errors++; $display("FAIL mid_release got %h/%b exp 0/0", rdata1, stallreq);
        end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] e1, e2;
        logic        es;
        for (int n = 0; n < 400; n++) begin
            we         = ($urandom_range(0, 1) == 1);
            waddr      = 5'($urandom_range(0, 7));
            wdata      = $urandom;
            re1        = ($urandom_range(0, 3) != 0);
            raddr1     = 5'($urandom_range(0, 7));
            re2        = ($urandom_range(0, 3) != 0);
            raddr2     = 5'($urandom_range(0, 7));
            issue_we   = ($urandom_range(0, 4) < 3);
            issue_addr = 5'($urandom_range(0, 7));
            #1;
            e1 = m_read(re1, raddr1);
            e2 = m_read(re2, raddr2);
            es = m_stall();
            checks++;
            if (rdata1 !== e1) begin errors++; $display("FAIL rnd%0d_rdata1 got %h exp %h", n, rdata1, e1); end
            checks++;
            if (rdata2 !== e2) begin errors++; $display("FAIL rnd%0d_rdata2 got %h exp %h", n, rdata2, e2); end
            checks++;
            if (stallreq !== es) begin errors++; $display("FAIL rnd%0d_stall got %b exp %b", n, stallreq, es); end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_hazard();
        test_full();
        test_zero();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
